fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 39 +++
 rtl/fetch_wb_reg.sv | 63 ++++++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam int          EXP_W_DEF    = 12;

  // Bit positions inside the per-instruction exception field
  localparam int EXP_ADEL   = 0;
  localparam int EXP_BUSERR = 1;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_REQ     = 2'd1;
  localparam fetch_state_t ST_WAIT    = 2'd2;
  localparam fetch_state_t ST_DISCARD = 2'd3;

  typedef struct packed {
    logic        adel;
    logic        err;
    logic [31:0] pc;
    logic [63:0] data;
  } wb_req_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch sequencer bus: redirect input, I-cache request/response, FIFO write side.
interface fetch_if #(parameter int EXP_W = 12);
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_keep_ds;
  logic             fifo_full;
  logic             ireq_valid;
  logic [31:0]      ireq_addr;
  logic             ireq_ready;
  logic             iresp_valid;
  logic [63:0]      iresp_data;
  logic             iresp_err;
  logic             fifo_rst;
  logic             fifo_rst_with_delay;
  logic             fifo_we1;
  logic             fifo_we2;
  logic [31:0]      fifo_wdata1;
  logic [31:0]      fifo_wdata2;
  logic [31:0]      fifo_waddr1;
  logic [31:0]      fifo_waddr2;
  logic [EXP_W-1:0] fifo_wexp1;
  logic [31:0]      stall_cycles;

  modport master (
    input  redirect_valid, redirect_pc, redirect_keep_ds, fifo_full,
           ireq_ready, iresp_valid, iresp_data, iresp_err,
    output ireq_valid, ireq_addr, fifo_rst, fifo_rst_with_delay,
           fifo_we1, fifo_we2, fifo_wdata1, fifo_wdata2,
           fifo_waddr1, fifo_waddr2, fifo_wexp1, stall_cycles
  );

  modport slave (
    output redirect_valid, redirect_pc, redirect_keep_ds, fifo_full,
           ireq_ready, iresp_valid, iresp_data, iresp_err,
    input  ireq_valid, ireq_addr, fifo_rst, fifo_rst_with_delay,
           fifo_we1, fifo_we2, fifo_wdata1, fifo_wdata2,
           fifo_waddr1, fifo_waddr2, fifo_wexp1, stall_cycles
  );
endinterface

// File: rtl/fetch_wb_reg.sv
// Registered FIFO-write stage: turns one fetch result into one or two FIFO entries.
module fetch_wb_reg
  import fetch_pkg::*;
#(
  parameter int EXP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             cancel,
  input  wb_req_t          req,
  output logic             we1,
  output logic             we2,
  output logic [31:0]      wdata1,
  output logic [31:0]      wdata2,
  output logic [31:0]      waddr1,
  output logic [31:0]      waddr2,
  output logic [EXP_W-1:0] wexp1
);

  logic [EXP_W-1:0] exp_n;

  always_comb begin
    exp_n             = '0;
    exp_n[EXP_ADEL]   = req.adel;
    exp_n[EXP_BUSERR] = req.err;
  end

  // Outputs are single-cycle pulses; everything returns to zero when idle.
  always_ff @(posedge clk) begin
    if (rst || cancel || !load) begin
      we1    <= 1'b0;
      we2    <= 1'b0;
      wdata1 <= '0;
      wdata2 <= '0;
      waddr1 <= '0;
      waddr2 <= '0;
      wexp1  <= '0;
    end else begin
      we1    <= 1'b1;
      waddr1 <= req.pc;
      wexp1  <= exp_n;
      if (req.adel) begin
        we2    <= 1'b0;
        wdata1 <= '0;
        wdata2 <= '0;
        waddr2 <= '0;
      end else if (!req.pc[2]) begin
        we2    <= 1'b1;
        wdata1 <= req.data[31:0];
        wdata2 <= req.data[63:32];
        waddr2 <= req.pc + 32'd4;
      end else begin
        // Fetch entered mid-pair: only the upper word belongs to the stream
        we2    <= 1'b0;
        wdata1 <= req.data[63:32];
        wdata2 <= '0;
        waddr2 <= '0;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the PC, issues 64-bit I-cache requests, feeds the FIFO.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          EXP_W    = EXP_W_DEF
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, req_pc, stall_cnt;
  logic         halted, halted_n;
  logic         flush, flush_ds;
  logic         aligned, req_vld, fire, adel_wr, resp_wr;
  wb_req_t      wb_req;

  assign aligned = (pc[1:0] == 2'b00);
  assign req_vld = (state == ST_REQ) && !bus.fifo_full && aligned;
  assign fire    = req_vld && bus.ireq_ready;
  // Misaligned PC never reaches the cache; it becomes a single ADEL entry instead.
  assign adel_wr = (state == ST_REQ) && !aligned && !bus.fifo_full && !bus.redirect_valid;
  assign resp_wr = (state == ST_WAIT) && bus.iresp_valid && !bus.redirect_valid;

  always_comb begin
    wb_req      = '0;
    wb_req.adel = adel_wr;
    wb_req.err  = resp_wr && bus.iresp_err;
    wb_req.pc   = adel_wr ? pc : req_pc;
    wb_req.data = bus.iresp_data;
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    halted_n = halted;
    case (state)
      ST_IDLE:    if (!halted) state_n = ST_REQ;
      ST_REQ: begin
        if (fire) state_n = ST_WAIT;
        else if (adel_wr) begin
          state_n  = ST_IDLE;
          halted_n = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.iresp_valid) begin
          state_n = ST_REQ;
          pc_n    = {pc[31:3] + 29'd1, 3'b000};
        end
      end
      default:    if (bus.iresp_valid) state_n = ST_REQ;
    endcase
    // Redirect overrides everything; DISCARD covers a response still owed to us.
    if (bus.redirect_valid) begin
      pc_n     = bus.redirect_pc;
      halted_n = 1'b0;
      case (state)
        ST_WAIT:    state_n = bus.iresp_valid ? ST_REQ : ST_DISCARD;
        ST_REQ:     state_n = fire ? ST_DISCARD : ST_REQ;
        ST_DISCARD: state_n = bus.iresp_valid ? ST_REQ : ST_DISCARD;
        default:    state_n = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_pc    <= '0;
      halted    <= 1'b0;
      flush     <= 1'b0;
      flush_ds  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      halted   <= halted_n;
      flush    <= bus.redirect_valid;
      flush_ds <= bus.redirect_valid && bus.redirect_keep_ds;
      if (fire) req_pc <= pc;
      if (state == ST_REQ && bus.fifo_full && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.ireq_valid          = req_vld;
  assign bus.ireq_addr           = req_vld ? {pc[31:3], 3'b000} : 32'h0;
  assign bus.fifo_rst            = flush;
  assign bus.fifo_rst_with_delay = flush_ds;
  assign bus.stall_cycles        = stall_cnt;

  fetch_wb_reg #(.EXP_W(EXP_W)) u_wb (
    .clk    (clk),
    .rst    (rst),
    .load   (adel_wr || resp_wr),
    .cancel (bus.redirect_valid),
    .req    (wb_req),
    .we1    (bus.fifo_we1),
    .we2    (bus.fifo_we2),
    .wdata1 (bus.fifo_wdata1),
    .wdata2 (bus.fifo_wdata2),
    .waddr1 (bus.fifo_waddr1),
    .waddr2 (bus.fifo_waddr2),
    .wexp1  (bus.fifo_wexp1)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on negedge, outputs checked 1ns later.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fetch_if #(.EXP_W(12)) bus ();

  fetch_ctrl #(.RESET_PC(32'hBFC0_0000), .EXP_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = '0;
    bus.redirect_keep_ds = 1'b0;
    bus.fifo_full        = 1'b0;
    bus.ireq_ready       = 1'b1;
    bus.iresp_valid      = 1'b0;
    bus.iresp_data       = '0;
    bus.iresp_err        = 1'b0;

    @(negedge clk); @(negedge clk); #1;
    chk("rst_ireq_valid", bus.ireq_valid, 0);
    chk("rst_ireq_addr", bus.ireq_addr, 0);
    chk("rst_we1", bus.fifo_we1, 0);
    chk("rst_fifo_rst", bus.fifo_rst, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    rst = 1'b0;

    // Sequential fetch from reset PC
    @(negedge clk); #1;
    chk("seq_valid0", bus.ireq_valid, 1);
    chk("seq_addr0", bus.ireq_addr, 32'hBFC0_0000);
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'h2222_2222_1111_1111; #1;
    chk("wait_no_req", bus.ireq_valid, 0);
    @(negedge clk);
    bus.iresp_valid = 1'b0; #1;
    chk("seq_we1", bus.fifo_we1, 1);
    chk("seq_we2", bus.fifo_we2, 1);
    chk("seq_waddr1", bus.fifo_waddr1, 32'hBFC0_0000);
    chk("seq_waddr2", bus.fifo_waddr2, 32'hBFC0_0004);
    chk("seq_wdata1", bus.fifo_wdata1, 32'h1111_1111);
    chk("seq_wdata2", bus.fifo_wdata2, 32'h2222_2222);
    chk("seq_wexp", bus.fifo_wexp1, 0);
    chk("seq_addr1", bus.ireq_addr, 32'hBFC0_0008);
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'h4444_4444_3333_3333; #1;
    @(negedge clk);
    bus.iresp_valid = 1'b0; #1;
    chk("seq2_we2", bus.fifo_we2, 1);
    chk("seq2_waddr1", bus.fifo_waddr1, 32'hBFC0_0008);
    chk("seq2_waddr2", bus.fifo_waddr2, 32'hBFC0_000C);

    // Redirect to an odd-word target while REQ is held off by ready=0
    bus.ireq_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0104;
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.ireq_ready = 1'b1; #1;
    chk("rd1_fifo_rst", bus.fifo_rst, 1);
    chk("rd1_rst_wd", bus.fifo_rst_with_delay, 0);
    chk("rd1_addr", bus.ireq_addr, 32'h8000_0100);
    chk("rd1_no_we", bus.fifo_we1, 0);
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'hAAAA_AAAA_5555_5555; #1;
    chk("rd1_rst_pulse_end", bus.fifo_rst, 0);
    @(negedge clk);
    bus.iresp_valid = 1'b0; #1;
    chk("odd_we1", bus.fifo_we1, 1);
    chk("odd_we2", bus.fifo_we2, 0);
    chk("odd_wdata1", bus.fifo_wdata1, 32'hAAAA_AAAA);
    chk("odd_waddr1", bus.fifo_waddr1, 32'h8000_0104);
    chk("odd_next_addr", bus.ireq_addr, 32'h8000_0108);

    // Redirect while WAIT, keep delay slot; stale response must vanish
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0200; bus.redirect_keep_ds = 1'b1; #1;
    chk("wait_valid", bus.ireq_valid, 0);
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.redirect_keep_ds = 1'b0;
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'hDEAD_BEEF_DEAD_BEEF; #1;
    chk("rd2_fifo_rst", bus.fifo_rst, 1);
    chk("rd2_rst_wd", bus.fifo_rst_with_delay, 1);
    chk("discard_no_req", bus.ireq_valid, 0);
    @(negedge clk);
    bus.iresp_valid = 1'b0; #1;
    chk("discard_no_we1", bus.fifo_we1, 0);
    chk("discard_no_we2", bus.fifo_we2, 0);
    chk("rd2_rst_end", bus.fifo_rst, 0);
    chk("rd2_addr", bus.ireq_addr, 32'h8000_0200);
    chk("stall_before", bus.stall_cycles, 0);

    // FIFO full for five cycles in REQ
    bus.fifo_full = 1'b1; #1;
    chk("full_valid", bus.ireq_valid, 0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("full_hold_valid", bus.ireq_valid, 0);
    end
    @(negedge clk);
    bus.fifo_full = 1'b0; #1;
    chk("stall_cnt", bus.stall_cycles, 5);
    chk("resume_valid", bus.ireq_valid, 1);
    chk("resume_addr", bus.ireq_addr, 32'h8000_0200);

    // Bus error on a response
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_err = 1'b1; bus.iresp_data = 64'h4444_4444_3333_3333; #1;
    @(negedge clk);
    bus.iresp_valid = 1'b0; bus.iresp_err = 1'b0; #1;
    chk("err_we1", bus.fifo_we1, 1);
    chk("err_we2", bus.fifo_we2, 1);
    chk("err_wexp", bus.fifo_wexp1, 12'h002);
    chk("err_waddr2", bus.fifo_waddr2, 32'h8000_0204);
    chk("err_wdata2", bus.fifo_wdata2, 32'h4444_4444);

    // Misaligned redirect target
    bus.ireq_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0002;
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.ireq_ready = 1'b1; #1;
    chk("mis_no_req", bus.ireq_valid, 0);
    chk("mis_fifo_rst", bus.fifo_rst, 1);
    @(negedge clk); #1;
    chk("mis_we1", bus.fifo_we1, 1);
    chk("mis_we2", bus.fifo_we2, 0);
    chk("mis_waddr1", bus.fifo_waddr1, 32'h8000_0002);
    chk("mis_wdata1", bus.fifo_wdata1, 0);
    chk("mis_wexp", bus.fifo_wexp1, 12'h001);
    chk("mis_no_req2", bus.ireq_valid, 0);
    @(negedge clk); #1;
    chk("park_we1", bus.fifo_we1, 0);
    chk("park_valid", bus.ireq_valid, 0);
    @(negedge clk); #1;
    chk("park_valid2", bus.ireq_valid, 0);

    // Redirect out of park, near the top of the address space
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect_valid = 1'b0; #1;
    chk("unpark_fifo_rst", bus.fifo_rst, 1);
    chk("unpark_valid", bus.ireq_valid, 1);
    chk("unpark_addr", bus.ireq_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'h0123_4567_89AB_CDEF; #1;
    @(negedge clk);
    bus.iresp_valid = 1'b0; #1;
    chk("wrap_waddr1", bus.fifo_waddr1, 32'hFFFF_FFF8);
    chk("wrap_waddr2", bus.fifo_waddr2, 32'hFFFF_FFFC);
    chk("wrap_wdata1", bus.fifo_wdata1, 32'h89AB_CDEF);
    chk("wrap_valid", bus.ireq_valid, 1);
    chk("wrap_addr", bus.ireq_addr, 32'h0000_0000);

    // Redirect coinciding with the response in WAIT
    @(negedge clk);
    bus.iresp_valid = 1'b1; bus.iresp_data = 64'h5555_5555_6666_6666;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0400; #1;
    @(negedge clk);
    bus.iresp_valid = 1'b0; bus.redirect_valid = 1'b0; #1;
    chk("coll_no_we1", bus.fifo_we1, 0);
    chk("coll_fifo_rst", bus.fifo_rst, 1);
    chk("coll_valid", bus.ireq_valid, 1);
    chk("coll_addr", bus.ireq_addr, 32'h8000_0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
